nodf_module_status: RTL and testbench

Synthesizable activity monitor for the `ap_ctrl_hs` block-level handshake of one non-dataflow HLS module, here the radiation_injector top. It watches `ap_start`, `ap_ready`, `ap_done` and `ap_continue`, and tracks module state, transaction counts and per-transaction latency and interval. It also emits one status record per completed transaction and a final summary record when `finish` is asserted. It sits beside the DUT top as a passive observer and never drives the handshake.

---
 rtl/nodf_module_status.sv | 172 +++++++++++++++++
 tb/tb_nodf_module_status.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/nodf_module_status.sv
// Passive monitor for one ap_ctrl_hs handshake: tracks block state, start/done
// counts, per-transaction latency and start-to-start interval, and emits records.
module nodf_module_status #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] min_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic [CNT_W-1:0] last_interval,
  output logic             rec_valid,
  output logic             final_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ONES = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] ivl_q, ivl_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] start_q, start_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [CNT_W-1:0] last_lat_q, last_lat_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] last_ivl_q, last_ivl_d;
  logic             rec_q, rec_d;
  logic             final_q, final_d;

  logic             live;
  logic             acc_start;
  logic             cmpl;
  logic [CNT_W-1:0] lat_smp;

  assign live      = (state_q != S_FIN);
  assign acc_start = live && ap_start && ap_ready;

  // Transaction tracking: lat_smp is the inclusive latency if this cycle completes.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    lat_smp = lat_q;
    cmpl    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          lat_d   = ONE;
          lat_smp = ONE;
          if (ap_done && ap_continue) cmpl = 1'b1;
          else if (ap_done)           state_d = S_HOLD;
          else                        state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        lat_d   = sat_inc(lat_q);
        lat_smp = sat_inc(lat_q);
        if (ap_done && ap_continue) begin
          cmpl = 1'b1;
          // A start coinciding with completion opens the next transaction at once.
          if (ap_start) lat_d = ONE;
          else          state_d = S_IDLE;
        end else if (ap_done) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        lat_d   = sat_inc(lat_q);
        lat_smp = sat_inc(lat_q);
        if (ap_continue) begin
          cmpl    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
    if (finish) state_d = S_FIN;
  end

  always_comb begin
    start_d    = acc_start ? sat_inc(start_q) : start_q;
    done_d     = done_q;
    last_lat_d = last_lat_q;
    min_d      = min_q;
    max_d      = max_q;
    if (cmpl) begin
      done_d     = sat_inc(done_q);
      last_lat_d = lat_smp;
      min_d      = (lat_smp < min_q) ? lat_smp : min_q;
      max_d      = (lat_smp > max_q) ? lat_smp : max_q;
    end
  end

  // Interval timer only runs once a first accepted start has been seen.
  always_comb begin
    ivl_d      = ivl_q;
    first_d    = first_q;
    last_ivl_d = last_ivl_q;
    if (live) begin
      if (first_q) ivl_d = sat_inc(ivl_q);
      if (acc_start) begin
        if (first_q) last_ivl_d = ivl_q;
        ivl_d   = ONE;
        first_d = 1'b1;
      end
    end
  end

  assign rec_d   = cmpl;
  assign final_d = live && finish;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      ivl_q      <= '0;
      first_q    <= 1'b0;
      start_q    <= '0;
      done_q     <= '0;
      last_lat_q <= '0;
      min_q      <= ONES;
      max_q      <= '0;
      last_ivl_q <= '0;
      rec_q      <= 1'b0;
      final_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      ivl_q      <= ivl_d;
      first_q    <= first_d;
      start_q    <= start_d;
      done_q     <= done_d;
      last_lat_q <= last_lat_d;
      min_q      <= min_d;
      max_q      <= max_d;
      last_ivl_q <= last_ivl_d;
      rec_q      <= rec_d;
      final_q    <= final_d;
    end
  end

  assign state         = state_q;
  assign start_cnt     = start_q;
  assign done_cnt      = done_q;
  assign last_latency  = last_lat_q;
  assign min_latency   = min_q;
  assign max_latency   = max_q;
  assign last_interval = last_ivl_q;
  assign rec_valid     = rec_q;
  assign final_valid   = final_q;

endmodule

// File: tb/tb_nodf_module_status.sv
// Directed bench for nodf_module_status with hand-computed expectations.
module tb_nodf_module_status;

  logic        clock = 1'b0;
  logic        reset;
  logic        ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [1:0]  state;
  logic [31:0] start_cnt, done_cnt, last_latency, min_latency, max_latency, last_interval;
  logic        rec_valid, final_valid;

  int n_checks = 0;
  int n_errors = 0;
  int rec_cnt  = 0;
  int fin_cnt  = 0;
  int r0, f0;

  nodf_module_status #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .finish(finish),
    .state(state), .start_cnt(start_cnt), .done_cnt(done_cnt),
    .last_latency(last_latency), .min_latency(min_latency), .max_latency(max_latency),
    .last_interval(last_interval), .rec_valid(rec_valid), .final_valid(final_valid)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rec_valid)   rec_cnt++;
    if (final_valid) fin_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Start in cycle 0, done in cycle lat-1, next start lands in cycle gap.
  task automatic txn(input int lat, input int gap);
    ap_start = 1'b1; ap_ready = 1'b1;
    tick();
    ap_start = 1'b0; ap_ready = 1'b0;
    repeat (lat - 2) tick();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    chk("txn_rec_valid", rec_valid, 1);
    chk("txn_latency", last_latency, lat);
    repeat (gap - lat) tick();
  endtask

  initial begin
    reset = 1'b0;
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("rst_state", state, 0);
    chk("rst_start_cnt", start_cnt, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_min", min_latency, 32'hFFFF_FFFF);
    chk("rst_max", max_latency, 0);
    chk("rst_last_lat", last_latency, 0);
    chk("rst_interval", last_interval, 0);
    chk("rst_pulses", rec_cnt + fin_cnt, 0);

    // Single transaction, latency 5
    r0 = rec_cnt;
    ap_start = 1; ap_ready = 1;
    tick();
    chk("t1_busy", state, 1);
    chk("t1_start_cnt", start_cnt, 1);
    ap_start = 0; ap_ready = 0;
    repeat (3) tick();
    ap_done = 1;
    tick();
    ap_done = 0;
    chk("t1_rec", rec_valid, 1);
    chk("t1_latency", last_latency, 5);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_idle", state, 0);
    tick();
    chk("t1_rec_low", rec_valid, 0);
    chk("t1_rec_once", rec_cnt - r0, 1);
    chk("t1_interval", last_interval, 0);

    // Three transactions 3, 7, 5 started 10 cycles apart
    do_reset();
    txn(3, 10);
    txn(7, 10);
    txn(5, 10);
    chk("t2_min", min_latency, 3);
    chk("t2_max", max_latency, 7);
    chk("t2_last", last_latency, 5);
    chk("t2_interval", last_interval, 10);
    chk("t2_done_cnt", done_cnt, 3);
    chk("t2_start_cnt", start_cnt, 3);

    // Output held off by ap_continue=0 for four cycles
    do_reset();
    r0 = rec_cnt;
    ap_start = 1; ap_ready = 1;
    tick();
    ap_start = 0; ap_ready = 0;
    tick();
    ap_done = 1; ap_continue = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_hold_state", state, 2);
      chk("t3_hold_norec", rec_valid, 0);
    end
    ap_continue = 1;
    tick();
    ap_done = 0;
    chk("t3_rec", rec_valid, 1);
    chk("t3_latency", last_latency, 7);
    chk("t3_idle", state, 0);
    tick();
    chk("t3_rec_once", rec_cnt - r0, 1);

    // Asynchronous reset while busy
    ap_start = 1; ap_ready = 1;
    tick();
    ap_start = 0; ap_ready = 0;
    repeat (2) tick();
    chk("t4_busy", state, 1);
    r0 = rec_cnt;
    reset = 1'b0;
    #2;
    chk("t4_async_state", state, 0);
    chk("t4_async_done", done_cnt, 0);
    chk("t4_async_start", start_cnt, 0);
    chk("t4_async_min", min_latency, 32'hFFFF_FFFF);
    chk("t4_async_lat", last_latency, 0);
    #2;
    reset = 1'b1;
    ap_done = 1;
    tick();
    ap_done = 0;
    chk("t4_orphan_done", done_cnt, 0);
    chk("t4_no_rec", rec_cnt - r0, 0);
    ap_ready = 1;
    tick();
    ap_ready = 0;
    chk("t4_ready_only", start_cnt, 0);
    txn(4, 6);
    chk("t4_done_cnt", done_cnt, 1);

    // Back-to-back: done and next start in the same busy cycle
    ap_start = 1; ap_ready = 1;
    tick();
    ap_start = 0; ap_ready = 0;
    tick();
    ap_start = 1; ap_ready = 1; ap_done = 1;
    tick();
    ap_start = 0; ap_ready = 0; ap_done = 0;
    chk("t5_b2b_state", state, 1);
    chk("t5_b2b_lat", last_latency, 3);
    chk("t5_b2b_interval", last_interval, 2);
    tick();
    ap_done = 1;
    tick();
    ap_done = 0;
    chk("t5_second_lat", last_latency, 3);
    chk("t5_start_cnt", start_cnt, 3);
    chk("t5_done_cnt", done_cnt, 3);
    chk("t5_min", min_latency, 3);
    chk("t5_max", max_latency, 4);

    // finish coinciding with a completion
    f0 = fin_cnt;
    ap_start = 1; ap_ready = 1;
    tick();
    ap_start = 0; ap_ready = 0;
    repeat (2) tick();
    ap_done = 1; finish = 1;
    tick();
    ap_done = 0;
    chk("t6_rec", rec_valid, 1);
    chk("t6_latency", last_latency, 4);
    chk("t6_done_cnt", done_cnt, 4);
    chk("t6_state", state, 3);
    chk("t6_final", final_valid, 1);
    for (int i = 0; i < 4; i++) begin
      ap_start = 1; ap_ready = 1; ap_done = i[0];
      tick();
    end
    ap_start = 0; ap_ready = 0; ap_done = 0;
    tick();
    chk("t6_frozen_start", start_cnt, 4);
    chk("t6_frozen_done", done_cnt, 4);
    chk("t6_frozen_state", state, 3);
    chk("t6_no_rec", rec_valid, 0);
    chk("t6_final_once", fin_cnt - f0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
